wr_stream_rr_arb: RTL and testbench
===================================

Name: wr_stream_rr_arb

Overview:
- N-channel write-stream arbiter.
- Merges NUM_CH independent valid/ready write streams into one registered output stream.
- Tags each output word with its source channel.
- Uses round-robin arbitration with an optional bounded burst hold, so one channel can send up to MAX_BURST back-to-back words before losing the grant.
- Sits between multiple producers and the elastic buffer's single write port.

Parameters:
- DATA_WIDTH, 20, width of each data word.
- NUM_CH, 4, number of input channels (2..16).
- MAX_BURST, 4, maximum consecutive transfers granted to one channel (>=1); 1 gives pure round-robin.

Ports:
- clk  input  1  clock; all logic on rising edge.
- arst_n  input  1  asynchronous active-low reset.
- data_in  input  NUM_CH*DATA_WIDTH  channel i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- vld  input  NUM_CH  per-channel valid.
- rdy  output  NUM_CH  per-channel ready; one-hot or zero.
- data_out  output  DATA_WIDTH  registered output data.
- vld_out  output  1  registered output valid.
- rdy_in  input  1  downstream ready.
- ch_id  output  CH_W  source channel of data_out; CH_W = max(1, $clog2(NUM_CH)).

Behaviour:
- Reset (async assert, sync release):
  - vld_out=0, data_out=0, ch_id=0.
  - owner=NUM_CH-1, burst_cnt=0.
  - rdy=0 while arst_n low.
- Output register:
  - load_en = !vld_out | rdy_in.
  - Transfer on input i when vld[i] & rdy[i].
  - Output word consumed when vld_out & rdy_in.
- Latency and throughput:
  - Latency input transfer -> vld_out is 1 cycle.
  - Full throughput: 1 word/cycle while rdy_in=1.
- Output register update on clk:
  - If load_en and any grant: data_out<=data_in[g], ch_id<=g, vld_out<=1.
  - Else if load_en: vld_out<=0; data_out and ch_id hold.
  - While vld_out=1 & rdy_in=0: data_out, ch_id and vld_out hold stable.
- Grant g, combinational, at most one:
  - Burst continuation: if burst_cnt!=0 and vld[owner], g=owner.
  - Otherwise: first i with vld[i], searching cyclically from owner+1 and ending at owner.
  - No vld: no grant.
- rdy[g] = load_en; all other rdy bits = 0.
  - rdy may depend on vld (grant computation); vld must not depend on rdy.
- Burst state, updated only on an input transfer from channel g:
  - Same-burst transfer (g==owner and burst_cnt!=0): burst_cnt <= (burst_cnt==MAX_BURST-1) ? 0 : burst_cnt+1.
  - New-burst transfer: burst_cnt <= (MAX_BURST==1) ? 0 : 1.
  - In both cases owner<=g.
  - Burst broken: if burst_cnt!=0 and !vld[owner], burst_cnt<=0 on that edge, even without a transfer.
  - Stall (load_en=0): owner and burst_cnt hold, except the burst-broken rule above.
- Boundary conditions:
  - Wrap-around: owner=NUM_CH-1 searches from channel 0.
  - Single requester: gets consecutive grants. Each completed burst restarts, since the search ends at owner.
  - All channels valid, MAX_BURST=M: each channel gets exactly M consecutive words, order 0,1,..,NUM_CH-1,0...
  - rdy_in low with vld_out=1: all rdy=0, no state change.
  - Reset mid-operation: the in-flight output word is discarded.
- Protocol:
  - Upstream holds data_in and vld stable until its transfer occurs.
  - The block never drops or duplicates a word.

Test Plan:
- Reset then idle: arst_n low 3 cycles with vld=4'b1111 -> rdy=0, vld_out=0. First grant after release is ch0.
- Pure round-robin: MAX_BURST=1, vld=4'b1111 constant, rdy_in=1 -> ch_id sequence 0,1,2,3,0,1; one word/cycle; 1-cycle latency.
- Burst hold: MAX_BURST=4, all valid, each channel sends incrementing data -> ch_id 0,0,0,0,1,1,1,1,2...; data order preserved per channel.
- Broken burst: ch2 valid 2 cycles then drops, ch3 valid -> 2 words ch2, next word ch3, burst_cnt cleared.
- Backpressure: rdy_in=0 for 5 cycles mid-stream -> data_out/ch_id/vld_out stable, rdy=0. On release, next word follows with no loss or duplicate; scoreboard counts match.
- Async reset during burst: arst_n pulsed low mid-cycle -> vld_out drops immediately; restart grants ch0 first.

Source files
------------

// File: rtl/wr_stream_rr_arb.sv
// Round-robin merge of NUM_CH valid/ready write streams into one registered,
// channel-tagged output stream, with a bounded per-channel burst hold.
module wr_stream_rr_arb #(
  parameter int DATA_WIDTH = 20,
  parameter int NUM_CH     = 4,
  parameter int MAX_BURST  = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            vld,
  output logic [NUM_CH-1:0]            rdy,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         vld_out,
  input  logic                         rdy_in,
  output logic [CH_W-1:0]              ch_id
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [DATA_WIDTH-1:0] din [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign din[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [CH_W-1:0]       owner_q, owner_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  vld_out_q, vld_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CH_W-1:0]       ch_id_q, ch_id_d;

  logic            gnt_vld;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W:0]   cand;
  logic            load_en;
  logic            burst_on;
  logic            xfer;

  assign load_en  = !vld_out_q | rdy_in;
  assign burst_on = (burst_q != '0);
  assign xfer     = gnt_vld & load_en;

  // Search wraps from owner+1 and ends at owner itself.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = owner_q;
    cand    = '0;
    if (burst_on && vld[owner_q]) begin
      gnt_vld = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = {1'b0, owner_q} + (CH_W+1)'(k);
        if (cand >= (CH_W+1)'(NUM_CH))
          cand = cand - (CH_W+1)'(NUM_CH);
        if (!gnt_vld && vld[cand[CH_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[CH_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (gnt_vld && arst_n)
      rdy[gnt_idx] = load_en;
  end

  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (xfer) begin
      owner_d = gnt_idx;
      if (gnt_idx == owner_q && burst_on)
        burst_d = (burst_q == BW'(MAX_BURST-1)) ? '0 : burst_q + 1'b1;
      else
        burst_d = (MAX_BURST == 1) ? '0 : BW'(1);
    end else if (burst_on && !vld[owner_q]) begin
      burst_d = '0;
    end
  end

  always_comb begin
    vld_out_d  = vld_out_q;
    data_out_d = data_out_q;
    ch_id_d    = ch_id_q;
    if (load_en) begin
      vld_out_d = gnt_vld;
      if (gnt_vld) begin
        data_out_d = din[gnt_idx];
        ch_id_d    = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      owner_q    <= CH_W'(NUM_CH-1);
      burst_q    <= '0;
      vld_out_q  <= 1'b0;
      data_out_q <= '0;
      ch_id_q    <= '0;
    end else begin
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      vld_out_q  <= vld_out_d;
      data_out_q <= data_out_d;
      ch_id_q    <= ch_id_d;
    end
  end

  assign data_out = data_out_q;
  assign vld_out  = vld_out_q;
  assign ch_id    = ch_id_q;

endmodule

// File: tb/tb_wr_stream_rr_arb.sv
// Randomized scoreboard bench for wr_stream_rr_arb: a pure round-robin
// instance and a burst-hold instance run side by side against one model.
module tb_wr_stream_rr_arb;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int CW = 2;
  localparam int MB [2] = '{1, 4};

  logic clk = 1'b0;
  logic arst_n;
  logic rdy_in;
  always #5 clk = ~clk;

  logic [N*DW-1:0] din  [2];
  logic [N-1:0]    vld  [2];
  logic [N-1:0]    rdy  [2];
  logic [DW-1:0]   dout [2];
  logic            vout [2];
  logic [CW-1:0]   chid [2];

  wr_stream_rr_arb #(.DATA_WIDTH(DW), .NUM_CH(N), .MAX_BURST(1)) u_rr (
    .clk(clk), .arst_n(arst_n), .data_in(din[0]), .vld(vld[0]),
    .rdy(rdy[0]), .data_out(dout[0]), .vld_out(vout[0]),
    .rdy_in(rdy_in), .ch_id(chid[0]));

  wr_stream_rr_arb #(.DATA_WIDTH(DW), .NUM_CH(N), .MAX_BURST(4)) u_bu (
    .clk(clk), .arst_n(arst_n), .data_in(din[1]), .vld(vld[1]),
    .rdy(rdy[1]), .data_out(dout[1]), .vld_out(vout[1]),
    .rdy_in(rdy_in), .ch_id(chid[1]));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Producers
  int budget [2][N];
  int seq    [2][N];
  bit xfer   [2][N];
  int p_on, p_stay;
  bit rin_next, rin_rand;

  // Reference model
  int own [2];
  int run [2];
  bit oval [2];
  logic [CW+DW-1:0] sb [2][$];
  int lg [2][$];

  function automatic logic [DW-1:0] word(input int c, input int s);
    return {4'(c), 16'(s)};
  endfunction

  function automatic bit in_burst(input int l);
    return run[l] > 0 && run[l] < MB[l];
  endfunction

  function automatic int mgrant(input int l, input logic [N-1:0] v);
    if (in_burst(l) && v[own[l]]) return own[l];
    for (int k = 1; k <= N; k++)
      if (v[(own[l] + k) % N]) return (own[l] + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      own[l]  = N - 1;
      run[l]  = 0;
      oval[l] = 1'b0;
      sb[l].delete();
      for (int c = 0; c < N; c++) xfer[l][c] = 1'b0;
    end
  endtask

  task automatic model_cycle();
    for (int l = 0; l < 2; l++) begin
      int g;
      bit le;
      logic [N-1:0] er;
      le = !oval[l] || rdy_in;
      g  = mgrant(l, vld[l]);
      er = '0;
      if (g >= 0 && le) er[g] = 1'b1;
      chk($sformatf("rdy_l%0d", l), rdy[l], er);
      chk($sformatf("vld_out_l%0d", l), vout[l], oval[l]);
      for (int c = 0; c < N; c++) xfer[l][c] = (g == c) && le;
      if (g >= 0 && le) begin
        sb[l].push_back({CW'(g), word(g, seq[l][g])});
        if (g == own[l] && in_burst(l)) run[l]++;
        else run[l] = 1;
        own[l] = g;
      end else if (in_burst(l) && !vld[l][own[l]]) begin
        run[l] = 0;
      end
      if (le) oval[l] = (g >= 0);
    end
  endtask

  task automatic prod_update();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < N; c++) begin
        if (xfer[l][c]) begin
          xfer[l][c] = 1'b0;
          seq[l][c]++;
          if (budget[l][c] > 0) budget[l][c]--;
          vld[l][c] = (budget[l][c] != 0) &&
                      (int'($urandom % 100) < p_stay);
        end else if (!vld[l][c]) begin
          vld[l][c] = (budget[l][c] != 0) &&
                      (int'($urandom % 100) < p_on);
        end
        din[l][c*DW +: DW] = word(c, seq[l][c]);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    prod_update();
    rdy_in = rin_rand ? (($urandom % 100) < 70) : rin_next;
    @(negedge clk);
    if (arst_n) model_cycle();
  endtask

  task automatic set_budget(input int c, input int b);
    for (int l = 0; l < 2; l++) budget[l][c] = b;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rin_rand = 1'b0;
    rin_next = 1'b1;
    do begin
      step();
      n++;
    end while (n < 60 && (vld[0] != 0 || vld[1] != 0 || vout[0] || vout[1]));
    if (n >= 60) chk("drain_timeout", 0, 1);
  endtask

  // Output monitor: pops the scoreboard on every consumed word and
  // checks the output register stays frozen under backpressure.
  logic [CW+DW-1:0] hold  [2];
  bit               stall [2];

  always @(negedge clk) begin
    if (!arst_n) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (stall[l]) begin
          chk($sformatf("stall_vld_l%0d", l), vout[l], 1'b1);
          chk($sformatf("stall_word_l%0d", l), {chid[l], dout[l]}, hold[l]);
        end
        if (vout[l] && rdy_in) begin
          if (sb[l].size() == 0) begin
            chk($sformatf("unexpected_word_l%0d", l), {chid[l], dout[l]}, 0);
          end else begin
            logic [CW+DW-1:0] e;
            e = sb[l].pop_front();
            chk($sformatf("word_l%0d", l), {chid[l], dout[l]}, e);
            lg[l].push_back(int'(chid[l]));
          end
        end
        stall[l] = vout[l] && !rdy_in;
        hold[l]  = {chid[l], dout[l]};
      end
    end
  end

  int e_rr [5] = '{2, 3, 2, 3, 3};
  int e_bu [5] = '{2, 2, 3, 3, 3};

  initial begin
    arst_n   = 1'b0;
    rdy_in   = 1'b1;
    rin_next = 1'b1;
    rin_rand = 1'b0;
    p_on     = 100;
    p_stay   = 100;
    stall[0] = 1'b0;
    stall[1] = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < N; c++) begin
        budget[l][c] = -1;
        seq[l][c]    = 0;
        xfer[l][c]   = 1'b0;
        vld[l][c]    = 1'b1;
        din[l][c*DW +: DW] = word(c, 0);
      end
    model_reset();

    repeat (3) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("rst_rdy_l%0d", l), rdy[l], 0);
        chk($sformatf("rst_vld_out_l%0d", l), vout[l], 0);
        chk($sformatf("rst_data_l%0d", l), dout[l], 0);
        chk($sformatf("rst_ch_id_l%0d", l), chid[l], 0);
      end
    end
    @(posedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
    model_cycle();
    for (int l = 0; l < 2; l++)
      chk($sformatf("first_grant_l%0d", l), rdy[l], 4'b0001);

    // All channels valid: pure rotation vs. bursts of four
    repeat (24) step();
    chk("rr_log_len", lg[0].size() >= 16, 1);
    chk("bu_log_len", lg[1].size() >= 16, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rr_order_%0d", k), lg[0][k], k % N);
      chk($sformatf("bu_order_%0d", k), lg[1][k], (k / 4) % N);
    end

    // Backpressure
    rin_next = 1'b0;
    repeat (5) step();
    rin_next = 1'b1;
    repeat (8) step();

    // Asynchronous reset in the middle of a burst
    @(posedge clk);
    #1 prod_update();
    #2 arst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("arst_vld_out_l%0d", l), vout[l], 0);
      chk($sformatf("arst_rdy_l%0d", l), rdy[l], 0);
      chk($sformatf("arst_data_l%0d", l), dout[l], 0);
    end
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
    model_cycle();
    for (int l = 0; l < 2; l++)
      chk($sformatf("restart_grant_l%0d", l), rdy[l], 4'b0001);
    repeat (10) step();

    // Broken burst: ch2 offers two words, ch3 joins after the first
    for (int c = 0; c < N; c++) set_budget(c, 0);
    drain();
    lg[0].delete();
    lg[1].delete();
    set_budget(2, 2);
    step();
    set_budget(3, 3);
    drain();
    chk("broken_rr_len", lg[0].size(), 5);
    chk("broken_bu_len", lg[1].size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("broken_rr_%0d", k), lg[0][k], e_rr[k]);
      chk($sformatf("broken_bu_%0d", k), lg[1][k], e_bu[k]);
    end

    // Randomized traffic and backpressure
    for (int c = 0; c < N; c++) set_budget(c, -1);
    rin_rand = 1'b1;
    for (int s = 0; s < 10; s++) begin
      p_on   = $urandom_range(10, 100);
      p_stay = $urandom_range(0, 100);
      repeat (150) step();
    end
    for (int c = 0; c < N; c++) set_budget(c, 0);
    drain();
    chk("sb_empty_rr", sb[0].size(), 0);
    chk("sb_empty_bu", sb[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
